// File: rtl/pipeline_pkg.sv
// Shared definitions for the program-load controller.
//   state_t         : controller state encoding (IDLE..ERR)
//   DEFAULT_ADDR_W  : default instruction-memory address width
//   DEFAULT_DATA_W  : default instruction word width
//   accepts_start() : true in the states where a start pulse begins a load
package pipeline_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FM_CLR  = 3'd1,
        LOAD    = 3'd2,
        CPU_RST = 3'd3,
        RUN     = 3'd4,
        ERR     = 3'd5
    } state_t;

    // Quiescent states: a start pulse here (re)starts the load sequence.
    function automatic logic accepts_start(input state_t s);
        return (s == IDLE) || (s == RUN) || (s == ERR);
    endfunction

endpackage

// File: rtl/program_load_ctrl_pulse_counter.sv
// pulse_counter: loadable down-counter with a terminal flag.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset (count clears to 0)
//   load     : load load_val this cycle (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, saturating at zero
//   terminal : count is zero
// Loading N-1 and leaving on terminal gives a phase lasting exactly N cycles.
module pulse_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         terminal
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign terminal = (count_reg == '0);

endmodule

// File: rtl/program_load_ctrl.sv
// program_load_ctrl: boot-time sequencer for instruction-memory load and
// processor reset release.
//   clk, reset        : clock and asynchronous active-low reset
//   start             : one-cycle pulse, begins (or restarts) a load
//   base_addr         : first write address, sampled on start
//   word_count        : number of words to load, sampled on start
//   in_valid/in_data  : instruction word stream
//   in_ready          : combinational; word accepted when in_valid && in_ready
//   fm_we/addr/data   : instruction-memory write port (registered)
//   fm_rst            : instruction-memory reset, active-high
//   cpu_reset         : processor reset, active-high, low only in RUN
//   busy/done/error   : FM_CLR|LOAD|CPU_RST / RUN / ERR status
module program_load_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int CNT_W          = 16,
    parameter int FM_RST_CYCLES  = 2,
    parameter int CPU_RST_CYCLES = 2,
    parameter int TIMEOUT        = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fm_we,
    output logic [ADDR_W-1:0] fm_addr,
    output logic [DATA_W-1:0] fm_data,
    output logic              fm_rst,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int PHASE_MAX = (FM_RST_CYCLES > CPU_RST_CYCLES) ? FM_RST_CYCLES : CPU_RST_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int IDLE_W    = $clog2(TIMEOUT + 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  index_reg;
    logic [CNT_W-1:0]  index_next;
    logic              fm_we_reg;
    logic [ADDR_W-1:0] fm_addr_reg;
    logic [DATA_W-1:0] fm_data_reg;
    logic              fm_rst_reg;
    logic              cpu_reset_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;

    logic               transfer;
    logic               last_xfer;
    logic               phase_load;
    logic [PHASE_W-1:0] phase_load_val;
    logic               phase_dec;
    logic               phase_term;
    logic               idle_load;
    logic               idle_dec;
    logic               idle_term;

    assign in_ready   = (state_reg == LOAD) && (index_reg < count_reg);
    assign transfer   = in_ready && in_valid;
    assign index_next = index_reg + CNT_W'(1);
    assign last_xfer  = transfer && (index_next == count_reg);

    // Phase counter times both FM_CLR and CPU_RST. FM_CLR is armed by start;
    // CPU_RST is armed on the edge that leaves FM_CLR (empty load) or issues
    // the last write.
    always_comb begin
        phase_load     = 1'b0;
        phase_load_val = PHASE_W'(FM_RST_CYCLES - 1);
        phase_dec      = (state_reg == FM_CLR) || (state_reg == CPU_RST);
        if (accepts_start(state_reg) && start) begin
            phase_load = 1'b1;
        end else if ((state_reg == FM_CLR) && phase_term && (count_reg == '0)) begin
            phase_load     = 1'b1;
            phase_load_val = PHASE_W'(CPU_RST_CYCLES - 1);
        end else if (last_xfer) begin
            phase_load     = 1'b1;
            phase_load_val = PHASE_W'(CPU_RST_CYCLES - 1);
        end
    end

    // Idle counter: rearmed on LOAD entry and on every transfer, so ERR is
    // taken after exactly TIMEOUT consecutive non-transfer LOAD cycles.
    always_comb begin
        idle_load = ((state_reg == FM_CLR) && phase_term) || transfer;
        idle_dec  = (state_reg == LOAD) && !transfer;
    end

    pulse_counter #(.W(PHASE_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (phase_load),
        .load_val (phase_load_val),
        .dec      (phase_dec),
        .terminal (phase_term)
    );

    pulse_counter #(.W(IDLE_W)) u_idle_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (idle_load),
        .load_val (IDLE_W'(TIMEOUT - 1)),
        .dec      (idle_dec),
        .terminal (idle_term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            count_reg     <= '0;
            index_reg     <= '0;
            fm_we_reg     <= 1'b0;
            fm_addr_reg   <= '0;
            fm_data_reg   <= '0;
            fm_rst_reg    <= 1'b0;
            cpu_reset_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            // Write enable is a single-cycle strobe; address/data hold.
            fm_we_reg <= 1'b0;
            case (state_reg)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        base_reg      <= base_addr;
                        count_reg     <= word_count;
                        index_reg     <= '0;
                        state_reg     <= FM_CLR;
                        fm_rst_reg    <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        error_reg     <= 1'b0;
                    end
                end
                FM_CLR: begin
                    if (phase_term) begin
                        fm_rst_reg <= 1'b0;
                        state_reg  <= (count_reg == '0) ? CPU_RST : LOAD;
                    end
                end
                LOAD: begin
                    if (transfer) begin
                        fm_we_reg   <= 1'b1;
                        fm_addr_reg <= base_reg + ADDR_W'(index_reg);
                        fm_data_reg <= in_data;
                        index_reg   <= index_next;
                        if (last_xfer) begin
                            state_reg <= CPU_RST;
                        end
                    end else if (idle_term) begin
                        state_reg <= ERR;
                        busy_reg  <= 1'b0;
                        error_reg <= 1'b1;
                    end
                end
                CPU_RST: begin
                    if (phase_term) begin
                        state_reg     <= RUN;
                        cpu_reset_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign fm_we     = fm_we_reg;
    assign fm_addr   = fm_addr_reg;
    assign fm_data   = fm_data_reg;
    assign fm_rst    = fm_rst_reg;
    assign cpu_reset = cpu_reset_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;

endmodule
